// File: rtl/rgb_pack.sv
// Registered {R,B,G} packer with matched sync/DE delay and output-side
// frame bookkeeping (column, line, start-of-frame, line-length consistency).
module rgb_pack #(
  parameter int LATENCY    = 2,
  parameter bit BLANK_ZERO = 1'b1
) (
  input  logic        in_PClk,
  input  logic        in_RstN,
  input  logic [7:0]  in_R,
  input  logic [7:0]  in_G,
  input  logic [7:0]  in_B,
  input  logic        in_HSync,
  input  logic        in_VSync,
  input  logic        in_DE,
  output logic [23:0] out_RGB,
  output logic        out_HSync,
  output logic        out_VSync,
  output logic        out_DE,
  output logic        out_Sof,
  output logic [11:0] out_PixCnt,
  output logic [11:0] out_LineCnt,
  output logic        out_LineErr
);

  localparam logic [11:0] CNT_MAX = 12'hFFF;

  function automatic logic [11:0] sat_inc(input logic [11:0] v);
    return (v == CNT_MAX) ? CNT_MAX : v + 12'd1;
  endfunction

  logic [23:0] w_pack;
  logic [26:0] w_stage_in;
  logic [26:0] r_pipe [LATENCY];
  logic        w_pre_vs;
  logic        w_pre_de;

  assign w_pack     = (BLANK_ZERO && !in_DE) ? 24'h000000 : {in_R, in_B, in_G};
  assign w_stage_in = {w_pack, in_HSync, in_VSync, in_DE};

  // Stage 1 registers the packed word; later stages are a plain delay line.
  always_ff @(posedge in_PClk or negedge in_RstN) begin
    if (!in_RstN) begin
      for (int i = 0; i < LATENCY; i++) r_pipe[i] <= '0;
    end else begin
      r_pipe[0] <= w_stage_in;
      for (int i = 1; i < LATENCY; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign out_RGB   = r_pipe[LATENCY-1][26:3];
  assign out_HSync = r_pipe[LATENCY-1][2];
  assign out_VSync = r_pipe[LATENCY-1][1];
  assign out_DE    = r_pipe[LATENCY-1][0];

  // Bookkeeping looks one stage ahead so its registers land with out_DE.
  generate
    if (LATENCY == 1) begin : g_pre_in
      assign w_pre_vs = in_VSync;
      assign w_pre_de = in_DE;
    end else begin : g_pre_pipe
      assign w_pre_vs = r_pipe[LATENCY-2][1];
      assign w_pre_de = r_pipe[LATENCY-2][0];
    end
  endgenerate

  logic        w_fs;
  logic        w_de_rise;
  logic        w_de_fall;
  logic        w_arm;
  logic [11:0] w_len;
  logic        r_arm;
  logic        r_sof;
  logic        r_framed;
  logic        r_refv;
  logic        r_err;
  logic [11:0] r_ref;
  logic [11:0] r_pix;
  logic [11:0] r_line;

  assign w_fs      = w_pre_vs & ~out_VSync;
  assign w_de_rise = w_pre_de & ~out_DE;
  assign w_de_fall = ~w_pre_de & out_DE;
  assign w_arm     = r_arm | w_fs;
  assign w_len     = sat_inc(r_pix);

  always_ff @(posedge in_PClk or negedge in_RstN) begin
    if (!in_RstN) begin
      r_arm    <= 1'b0;
      r_sof    <= 1'b0;
      r_framed <= 1'b0;
      r_refv   <= 1'b0;
      r_err    <= 1'b0;
      r_ref    <= '0;
      r_pix    <= '0;
      r_line   <= '0;
    end else begin
      r_sof <= w_arm & w_pre_de;
      r_arm <= w_arm & ~w_pre_de;
      if (w_fs) begin
        r_framed <= 1'b1;
        r_refv   <= 1'b0;
        r_err    <= 1'b0;
        r_ref    <= '0;
        r_pix    <= '0;
        r_line   <= '0;
      end else begin
        if (w_de_rise) r_pix <= '0;
        else if (w_pre_de) r_pix <= sat_inc(r_pix);
        if (w_de_fall) begin
          r_line <= sat_inc(r_line);
          // No reference is ever taken before the first frame start.
          if (r_framed) begin
            if (!r_refv) begin
              r_ref  <= w_len;
              r_refv <= 1'b1;
            end else if (w_len != r_ref) begin
              r_err <= 1'b1;
            end
          end
        end
      end
    end
  end

  assign out_Sof     = r_sof;
  assign out_PixCnt  = r_pix;
  assign out_LineCnt = r_line;
  assign out_LineErr = r_err;

endmodule

// File: tb/tb_rgb_pack.sv
// Bench for rgb_pack: random and directed video frames checked every cycle
// against a frame/line-level model, with literal pins on key scenarios.
module tb_rgb_pack;
  localparam int L1 = 2;
  localparam int L2 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [7:0] r, g, b;
  logic       hs, vs, de;

  logic [23:0] o1_RGB, o2_RGB;
  logic        o1_HS, o1_VS, o1_DE, o1_Sof, o1_Err;
  logic        o2_HS, o2_VS, o2_DE, o2_Sof, o2_Err;
  logic [11:0] o1_Pix, o1_Line, o2_Pix, o2_Line;

  rgb_pack #(.LATENCY(L1), .BLANK_ZERO(1'b1)) dut (
    .in_PClk(clk), .in_RstN(rst_n), .in_R(r), .in_G(g), .in_B(b),
    .in_HSync(hs), .in_VSync(vs), .in_DE(de),
    .out_RGB(o1_RGB), .out_HSync(o1_HS), .out_VSync(o1_VS), .out_DE(o1_DE),
    .out_Sof(o1_Sof), .out_PixCnt(o1_Pix), .out_LineCnt(o1_Line), .out_LineErr(o1_Err));

  rgb_pack #(.LATENCY(L2), .BLANK_ZERO(1'b0)) dut2 (
    .in_PClk(clk), .in_RstN(rst_n), .in_R(r), .in_G(g), .in_B(b),
    .in_HSync(hs), .in_VSync(vs), .in_DE(de),
    .out_RGB(o2_RGB), .out_HSync(o2_HS), .out_VSync(o2_VS), .out_DE(o2_DE),
    .out_Sof(o2_Sof), .out_PixCnt(o2_Pix), .out_LineCnt(o2_Line), .out_LineErr(o2_Err));

  int checks = 0;
  int failures = 0;

  function automatic void chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, got, exp, $time);
    end
  endfunction

  function automatic logic [23:0] pack_exp(input logic [26:0] w, input bit bz);
    return (bz && !w[0]) ? 24'h0 : {w[26:19], w[10:3], w[18:11]};
  endfunction

  // Input word captured on each clock edge since reset release: {R,G,B,HS,VS,DE}.
  logic [26:0] hist [0:16383];
  int e;

  // Reference model and per-cycle compare.
  initial begin
    logic [26:0] pend, x1, x2;
    bit pv, fs;
    int n, mline, mref, len, epix;
    bit framed, refcap, merr, marm, msof, pvs, pde;
    bit d_sof, d_err, d_de;
    int d_pix, d_line;
    pv = 0; e = 0; pend = '0;
    n = 0; mline = 0; mref = 0; framed = 0; refcap = 0; merr = 0; marm = 0; msof = 0;
    pvs = 0; pde = 0; epix = 0;
    d_sof = 0; d_err = 0; d_de = 0; d_pix = 0; d_line = 0;
    forever begin
      @(negedge clk);
      // dut2's bookkeeping sees dut1's output stream one cycle later.
      if (rst_n !== 1'b1) begin
        d_sof = 0; d_err = 0; d_de = 0; d_pix = 0; d_line = 0;
      end else begin
        d_sof = msof; d_err = merr; d_de = pde; d_pix = epix; d_line = mline;
      end
      if (rst_n !== 1'b1) begin
        e = 0; pv = 0;
        n = 0; mline = 0; mref = 0; framed = 0; refcap = 0; merr = 0; marm = 0; msof = 0;
        pvs = 0; pde = 0;
      end else begin
        if (pv && e < 16383) begin
          e++;
          hist[e] = pend;
          x1 = (e >= L1) ? hist[e-L1+1] : '0;
          fs = x1[1] && !pvs;
          msof = (marm || fs) && x1[0];
          marm = (marm || fs) && !x1[0];
          if (fs) begin
            mline = 0; framed = 1; refcap = 0; merr = 0; mref = 0;
            n = x1[0] ? 1 : 0;
          end else begin
            if (x1[0] && !pde) n = 1;
            else if (x1[0]) n = n + 1;
            if (!x1[0] && pde) begin
              len = (n > 4095) ? 4095 : n;
              if (framed) begin
                if (!refcap) begin mref = len; refcap = 1; end
                else if (len != mref) merr = 1;
              end
              if (mline < 4095) mline++;
            end
          end
          pvs = x1[1]; pde = x1[0];
        end
        pend = {r, g, b, hs, vs, de};
        pv = 1;
      end
      epix = (n == 0) ? 0 : ((n - 1 > 4095) ? 4095 : n - 1);
      x1 = (e >= L1) ? hist[e-L1+1] : '0;
      x2 = (e >= L2) ? hist[e-L2+1] : '0;
      chk("rgb",  o1_RGB, pack_exp(x1, 1'b1));
      chk("hs",   o1_HS,  x1[2]);
      chk("vs",   o1_VS,  x1[1]);
      chk("de",   o1_DE,  x1[0]);
      chk("sof",  o1_Sof, msof);
      chk("err",  o1_Err, merr);
      if (x1[0]) begin
        chk("pix",  o1_Pix,  epix);
        chk("line", o1_Line, mline);
      end
      if (rst_n !== 1'b1) begin
        chk("rst_pix",  o1_Pix,  0);
        chk("rst_line", o1_Line, 0);
      end
      chk("rgb2", o2_RGB, pack_exp(x2, 1'b0));
      chk("hs2",  o2_HS,  x2[2]);
      chk("vs2",  o2_VS,  x2[1]);
      chk("de2",  o2_DE,  x2[0]);
      chk("sof2", o2_Sof, d_sof);
      chk("err2", o2_Err, d_err);
      if (d_de) begin
        chk("pix2",  o2_Pix,  d_pix);
        chk("line2", o2_Line, d_line);
      end
    end
  end

  // Frame statistics used by the literal pins.
  int sofn, psum, lsum, pmax, sofpix, sofline, sofvs;
  initial forever begin
    @(negedge clk);
    if (o1_DE === 1'b1) begin
      psum += o1_Pix; lsum += o1_Line;
      if (o1_Pix > pmax) pmax = o1_Pix;
    end
    if (o1_Sof === 1'b1) begin
      sofn++; sofpix = o1_Pix; sofline = o1_Line; sofvs = o1_VS;
    end
  end

  task automatic clr();
    sofn = 0; psum = 0; lsum = 0; pmax = 0; sofpix = -1; sofline = -1; sofvs = -1;
  endtask

  task automatic drv(input logic [7:0] rr, gg, bb, input logic h, v, d);
    @(posedge clk); #2;
    r = rr; g = gg; b = bb; hs = h; vs = v; de = d;
  endtask

  task automatic idle(input int k);
    repeat (k) drv($urandom, $urandom, $urandom, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic line(input int len, input bit vs_first);
    for (int i = 0; i < len; i++)
      drv($urandom, $urandom, $urandom, 1'($urandom_range(0, 1)), vs_first && i == 0, 1'b1);
  endtask

  task automatic vpulse();
    drv($urandom, $urandom, $urandom, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic frame(input int nl, input int base, input int odd, input int oddlen);
    vpulse(); idle(2);
    for (int l = 0; l < nl; l++) begin
      line((l == odd) ? oddlen : base, 1'b0);
      idle(3);
    end
  endtask

  initial begin
    rst_n = 1'b0; r = 0; g = 0; b = 0; hs = 0; vs = 0; de = 0;
    clr();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("lit_rst_rgb", o1_RGB, 24'h0);
    chk("lit_rst_err", o1_Err, 0);
    @(posedge clk); #2; rst_n = 1'b1;

    drv(8'hAA, 8'h55, 8'hCC, 1'b0, 1'b0, 1'b1);
    drv(8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0);
    @(posedge clk); @(negedge clk);
    chk("lit_pack", o1_RGB, 24'hAACC55);
    chk("lit_pack_de", o1_DE, 1);
    @(posedge clk); @(negedge clk);
    chk("lit_blank", o1_RGB, 24'h0);
    @(posedge clk); @(negedge clk);
    chk("lit_noblank", o2_RGB, 24'hFFFFFF);

    clr();
    frame(3, 4, -1, 0); idle(5);
    chk("lit_sof_once", sofn, 1);
    chk("lit_pix_sum", psum, 18);
    chk("lit_line_sum", lsum, 12);
    chk("lit_no_err", o1_Err, 0);

    frame(3, 4, 1, 5); idle(5);
    chk("lit_err_set", o1_Err, 1);
    vpulse(); idle(5);
    chk("lit_err_clr", o1_Err, 0);

    clr();
    line(4, 1'b1); idle(6);
    chk("lit_sof_same", sofn, 1);
    chk("lit_sof_pix", sofpix, 0);
    chk("lit_sof_line", sofline, 0);
    chk("lit_sof_vs", sofvs, 1);

    vpulse(); idle(2); clr();
    line(4100, 1'b0); idle(3);
    line(4096, 1'b0); idle(6);
    chk("lit_pix_sat", pmax, 4095);
    chk("lit_sat_len_eq", o1_Err, 0);
    line(10, 1'b0); idle(6);
    chk("lit_sat_len_ne", o1_Err, 1);

    repeat (6) begin
      int nl, base, odd;
      nl = $urandom_range(2, 5);
      base = $urandom_range(1, 8);
      odd = ($urandom_range(0, 2) == 0) ? $urandom_range(1, nl - 1) : -1;
      frame(nl, base, odd, $urandom_range(1, 9));
    end

    vpulse(); idle(2);
    line(3, 1'b0);
    @(posedge clk); #2; rst_n = 1'b0;
    @(negedge clk);
    chk("lit_midrst_de", o1_DE, 0);
    chk("lit_midrst_rgb", o1_RGB, 24'h0);
    repeat (2) @(posedge clk);
    #2; rst_n = 1'b1;
    line(3, 1'b0); idle(2); line(6, 1'b0); idle(6);
    chk("lit_noref_err", o1_Err, 0);
    vpulse(); idle(2);
    line(4, 1'b0); idle(2); line(4, 1'b0); idle(6);
    chk("lit_ref_ok", o1_Err, 0);
    line(7, 1'b0); idle(6);
    chk("lit_ref_bad", o1_Err, 1);

    idle(4);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
